rf_op_sequencer: RTL and testbench
==================================

// Module: rf_op_sequencer
// PURPOSE
//  Upstream control stage for the RF register file (R1-R4 / T1-T4, FunSel 00 clr, 01 load, 10 dec, 11 inc).
//  Accepts one register-level command per valid/ready handshake and expands it into one or more cycles of RF controls.
//  RF controls driven: FunSel, RSel, TSel, O1Sel, O2Sel, i.
//  Supports multi-cycle ops: MOV (read via O1, then load) and ADDI/SUBI (repeated inc/dec).
// PARAMETERS
//  WIDTH  8  data width of rf_i, rf_o1, cmd_imm and the repeat counter
// PORTS
//  clk         in   1      rising-edge clock, same clock as RF
//  rst_n       in   1      asynchronous active-low reset
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      sequencer can accept; high only in IDLE
//  cmd_op      in   3      000 NOP, 001 CLR, 010 LDI, 011 INC, 100 DEC, 101 MOV, 110 ADDI, 111 SUBI
//  cmd_dst     in   3      destination code, O1Sel encoding: 000-011 T1-T4, 100-111 R1-R4
//  cmd_src     in   3      MOV source code, same encoding
//  cmd_imm     in   WIDTH  LDI data / ADDI-SUBI repeat count
//  rf_o1       in   WIDTH  RF O1 read data (combinational from RF)
//  rf_fun_sel  out  2      to RF FunSel
//  rf_r_sel    out  4      to RF RSel; bit3=R1 .. bit0=R4
//  rf_t_sel    out  4      to RF TSel; bit3=T1 .. bit0=T4
//  rf_o1_sel   out  3      to RF O1Sel
//  rf_o2_sel   out  3      to RF O2Sel
//  rf_i        out  WIDTH  to RF i
//  busy        out  1      ~cmd_ready
//  done        out  1      one-cycle pulse after final RF write edge of a command
// BEHAVIOUR
//  Reset values (async, immediate): state IDLE; all latches, counter and outputs 0, except cmd_ready=1.
//  Handshake: accept on a rising edge with cmd_valid & cmd_ready. Latch op/dst/src/imm; ignore inputs until back in IDLE.
//  States: IDLE, EXEC, READ, WRITE, REPEAT.
//  Transitions:
//   - accept NOP/CLR/LDI/INC/DEC -> EXEC; also ADDI/SUBI with imm==0 -> EXEC.
//   - accept MOV -> READ.
//   - accept ADDI/SUBI with imm!=0 -> REPEAT, count=imm.
//   - EXEC -> IDLE.
//   - READ -> WRITE; rf_o1 captured into data latch at this edge.
//   - WRITE -> IDLE.
//   - REPEAT: count decrements each cycle; at count==1 -> IDLE.
//  Enables:
//   - Exactly one bit of {rf_r_sel, rf_t_sel} is set, for dst, in EXEC (CLR/LDI/INC/DEC), WRITE and REPEAT.
//   - Both are 0000 in all other states, including NOP and imm==0 EXEC.
//  rf_fun_sel:
//   - CLR 00; LDI/MOV 01; DEC/SUBI 10; INC/ADDI 11.
//   - 01 when not writing (harmless, enables 0).
//  rf_i:
//   - LDI: latched imm.
//   - MOV: value captured in READ.
//   - otherwise holds last value.
//  rf_o1_sel = latched src; rf_o2_sel = latched dst (observe destination). Both hold after the command.
//  Latency: accept at edge k.
//   - Single-cycle ops write at edge k+1.
//   - MOV writes at edge k+2.
//   - ADDI/SUBI n write at edges k+1..k+n.
//   - done high during the cycle after the last write (state IDLE).
//   - Earliest next accept is the edge ending that done cycle.
//  Counter wrap: none. imm is unsigned, max 2^WIDTH-1 repeats. The RF register itself wraps modulo 2^WIDTH (RF behaviour).
//  MOV with src==dst: legal; reloads the same value.
//  Reset mid-operation: enables drop to 0 asynchronously; command abandoned; no done.
// TESTING
//  1. LDI R1 0x14:
//     - one cycle with fun_sel=01, r_sel=1000, t_sel=0000, rf_i=0x14.
//     - cmd_ready low 1 cycle; done next cycle.
//  2. ADDI T2 imm=3:
//     - 3 consecutive cycles with fun_sel=11, t_sel=0100, r_sel=0000; busy 3 cycles.
//     - done once; model RF T2 goes 0x14 -> 0x17.
//  3. SUBI R3 imm=0 and NOP:
//     - r_sel=t_sel=0000 throughout; done after exactly 1 busy cycle.
//  4. MOV R4<-T1 with rf_o1=0x5A during READ:
//     - READ o1_sel=000 with enables 0.
//     - WRITE rf_i=0x5A, fun_sel=01, r_sel=0001.
//     - done next cycle.
//  5. SUBI R2 imm=200, rst_n low at 50th REPEAT cycle:
//     - enables 0 immediately; no done; cmd_ready=1 after release.
//  6. cmd_valid held high during a busy ADDI with the next command changed mid-flight:
//     - the first command completes unaffected.
//     - the next command is accepted on the edge ending its done cycle.

Source files
------------

// File: rtl/rf_op_sequencer.sv
// Purpose : expands one register-level command into 1..n cycles of RF control (FunSel/RSel/TSel/O1Sel/O2Sel/i).
// Latency : accept at edge k; single ops write at k+1, MOV at k+2, ADDI/SUBI n at k+1..k+n; done pulses the cycle after.
// Backpr. : cmd_ready is high only in IDLE; a held cmd_valid is taken on the edge that ends the done cycle.
//
// Ports
//   clk, rst_n            rising-edge clock shared with the RF, async active-low reset
//   cmd_valid/cmd_ready   command handshake (accept on cmd_valid & cmd_ready at a rising edge)
//   cmd_op                000 NOP, 001 CLR, 010 LDI, 011 INC, 100 DEC, 101 MOV, 110 ADDI, 111 SUBI
//   cmd_dst, cmd_src      register codes, O1Sel encoding: 000-011 T1-T4, 100-111 R1-R4
//   cmd_imm               LDI data, or ADDI/SUBI repeat count
//   rf_o1                 RF O1 read data, sampled at the end of the MOV read cycle
//   rf_fun_sel .. rf_i    RF control outputs
//   busy, done            busy = ~cmd_ready; done = one-cycle pulse after a command's final write
module rf_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_dst,
  input  logic [2:0]       cmd_src,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [WIDTH-1:0] rf_o1,
  output logic [1:0]       rf_fun_sel,
  output logic [3:0]       rf_r_sel,
  output logic [3:0]       rf_t_sel,
  output logic [2:0]       rf_o1_sel,
  output logic [2:0]       rf_o2_sel,
  output logic [WIDTH-1:0] rf_i,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SUBI = 3'b111;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_DEC  = 2'b10;
  localparam logic [1:0] FUN_INC  = 2'b11;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_REPEAT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       dst_q, dst_d;
  logic [2:0]       src_q, src_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;

  // RF controls are registered and computed from the next state, so that they
  // line up with the state they describe and all read 0 while in reset.
  logic [1:0]       fun_sel_q, fun_sel_d;
  logic [3:0]       r_sel_q, r_sel_d;
  logic [3:0]       t_sel_q, t_sel_d;

  logic             writing;
  logic [3:0]       dst_onehot;

  // ---------------------------------------------------------------------------
  // Next-state and latch logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          dst_d = cmd_dst;
          src_d = cmd_src;
          // data latch only follows cmd_imm for LDI; ADDI/SUBI use imm as a count
          if (cmd_op == OP_LDI) begin
            data_d = cmd_imm;
          end
          if (cmd_op == OP_MOV) begin
            state_d = ST_READ;
          end else if (((cmd_op == OP_ADDI) || (cmd_op == OP_SUBI)) && (cmd_imm != '0)) begin
            state_d = ST_REPEAT;
            cnt_d   = cmd_imm;
          end else begin
            // includes NOP and zero-count ADDI/SUBI: one busy cycle, no write
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      ST_READ: begin
        // O1 is already steered to src; capture the read value for the write cycle
        data_d  = rf_o1;
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      ST_REPEAT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next RF control values, derived from the state the next cycle will be in
  // ---------------------------------------------------------------------------
  always_comb begin
    writing    = 1'b0;
    dst_onehot = 4'b1000 >> dst_d[1:0];
    fun_sel_d  = FUN_LOAD;
    r_sel_d    = 4'b0000;
    t_sel_d    = 4'b0000;

    case (state_d)
      ST_EXEC:   writing = (op_d == OP_CLR) || (op_d == OP_LDI) ||
                           (op_d == OP_INC) || (op_d == OP_DEC);
      ST_WRITE:  writing = 1'b1;
      ST_REPEAT: writing = 1'b1;
      default:   writing = 1'b0;
    endcase

    if (writing) begin
      case (op_d)
        OP_CLR:             fun_sel_d = FUN_CLR;
        OP_LDI, OP_MOV:     fun_sel_d = FUN_LOAD;
        OP_DEC, OP_SUBI:    fun_sel_d = FUN_DEC;
        OP_INC, OP_ADDI:    fun_sel_d = FUN_INC;
        default:            fun_sel_d = FUN_LOAD;
      endcase
      // codes 1xx select R1-R4, 0xx select T1-T4; low two bits pick the register
      if (dst_d[2]) begin
        r_sel_d = dst_onehot;
      end else begin
        t_sel_d = dst_onehot;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      dst_q     <= 3'b000;
      src_q     <= 3'b000;
      cnt_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      fun_sel_q <= 2'b00;
      r_sel_q   <= 4'b0000;
      t_sel_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      fun_sel_q <= fun_sel_d;
      r_sel_q   <= r_sel_d;
      t_sel_q   <= t_sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = ~cmd_ready;
  assign done       = done_q;
  assign rf_fun_sel = fun_sel_q;
  assign rf_r_sel   = r_sel_q;
  assign rf_t_sel   = t_sel_q;
  // O2 watches the destination so the result can be observed downstream
  assign rf_o1_sel  = src_q;
  assign rf_o2_sel  = dst_q;
  assign rf_i       = data_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
module tb_rf_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op, cmd_dst, cmd_src;
  logic [7:0] cmd_imm;
  logic [7:0] rf_o1;
  logic [1:0] rf_fun_sel;
  logic [3:0] rf_r_sel, rf_t_sel;
  logic [2:0] rf_o1_sel, rf_o2_sel;
  logic [7:0] rf_i;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  // Behavioural register file: index = register code (0-3 T1-T4, 4-7 R1-R4)
  logic [7:0] rf_model [8] = '{default: 8'h00};

  always #5 clk = ~clk;

  rf_op_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .rf_o1(rf_o1),
    .rf_fun_sel(rf_fun_sel), .rf_r_sel(rf_r_sel), .rf_t_sel(rf_t_sel),
    .rf_o1_sel(rf_o1_sel), .rf_o2_sel(rf_o2_sel), .rf_i(rf_i),
    .busy(busy), .done(done)
  );

  assign rf_o1 = rf_model[rf_o1_sel];

  always @(posedge clk) begin
    for (int c = 0; c < 8; c++) begin
      if ((c >= 4) ? rf_r_sel[3 - (c % 4)] : rf_t_sel[3 - (c % 4)]) begin
        case (rf_fun_sel)
          2'b00:   rf_model[c] <= 8'h00;
          2'b01:   rf_model[c] <= rf_i;
          2'b10:   rf_model[c] <= rf_model[c] - 8'd1;
          default: rf_model[c] <= rf_model[c] + 8'd1;
        endcase
      end
    end
  end

  // Issue a command at the current negedge and wait (bounded) for its done pulse.
  // Returns at the negedge of the done cycle.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src, input logic [7:0] imm);
    bit seen;
    seen = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL setup_done_timeout: op=%b dst=%b got no done within 300 cycles", op, dst); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_dst = 3'b000; cmd_src = 3'b000; cmd_imm = 8'h00;
    #2;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({rf_r_sel, rf_t_sel} !== 8'h00) begin errors++; $display("FAIL reset_enables: got %b want 00000000", {rf_r_sel, rf_t_sel}); end
    checks++; if (rf_fun_sel !== 2'b00) begin errors++; $display("FAIL reset_fun_sel: got %b want 00", rf_fun_sel); end
    checks++; if ({rf_i, rf_o1_sel, rf_o2_sel} !== 14'h0) begin errors++; $display("FAIL reset_data_sel: got i=%h o1=%b o2=%b want all 0", rf_i, rf_o1_sel, rf_o2_sel); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_ldi();
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_dst = 3'b100; cmd_src = 3'b000; cmd_imm = 8'h14;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (rf_fun_sel !== 2'b01) begin errors++; $display("FAIL ldi_fun_sel: got %b want 01", rf_fun_sel); end
    checks++; if (rf_r_sel !== 4'b1000 || rf_t_sel !== 4'b0000) begin errors++; $display("FAIL ldi_enables: got r=%b t=%b want r=1000 t=0000", rf_r_sel, rf_t_sel); end
    checks++; if (rf_i !== 8'h14) begin errors++; $display("FAIL ldi_rf_i: got %h want 14", rf_i); end
    checks++; if (cmd_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ldi_busy_cycle: got ready=%b done=%b want 0 0", cmd_ready, done); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL ldi_done: got done=%b ready=%b want 1 1", done, cmd_ready); end
    checks++; if (rf_r_sel !== 4'b0000) begin errors++; $display("FAIL ldi_idle_r_sel: got %b want 0000", rf_r_sel); end
    checks++; if (rf_model[4] !== 8'h14) begin errors++; $display("FAIL ldi_model_r1: got %h want 14", rf_model[4]); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ldi_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_addi();
    do_cmd(3'b010, 3'b001, 3'b000, 8'h14);   // LDI T2 0x14
    cmd_valid = 1'b1; cmd_op = 3'b110; cmd_dst = 3'b001; cmd_imm = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rf_fun_sel !== 2'b11 || rf_t_sel !== 4'b0100 || rf_r_sel !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL addi_cycle%0d: got fun=%b t=%b r=%b busy=%b done=%b want 11 0100 0000 1 0", i, rf_fun_sel, rf_t_sel, rf_r_sel, busy, done);
      end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || rf_t_sel !== 4'b0000) begin errors++; $display("FAIL addi_done: got done=%b busy=%b t=%b want 1 0 0000", done, busy, rf_t_sel); end
    checks++; if (rf_model[1] !== 8'h17) begin errors++; $display("FAIL addi_model_t2: got %h want 17", rf_model[1]); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL addi_done_once: got %b want 0", done); end
  endtask

  task automatic test_zero_and_nop();
    for (int k = 0; k < 2; k++) begin
      cmd_valid = 1'b1; cmd_op = (k == 0) ? 3'b111 : 3'b000; cmd_dst = 3'b110; cmd_imm = 8'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || rf_r_sel !== 4'b0000 || rf_t_sel !== 4'b0000) begin
        errors++; $display("FAIL noop%0d_busy_cycle: got busy=%b done=%b r=%b t=%b want 1 0 0000 0000", k, busy, done, rf_r_sel, rf_t_sel);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || rf_r_sel !== 4'b0000 || rf_t_sel !== 4'b0000) begin
        errors++; $display("FAIL noop%0d_done: got done=%b busy=%b r=%b t=%b want 1 0 0000 0000", k, done, busy, rf_r_sel, rf_t_sel);
      end
      @(negedge clk);
    end
    checks++; if (rf_model[6] !== 8'h00) begin errors++; $display("FAIL noop_model_r3: got %h want 00", rf_model[6]); end
  endtask

  task automatic test_mov();
    do_cmd(3'b010, 3'b000, 3'b000, 8'h5A);   // LDI T1 0x5A
    do_cmd(3'b010, 3'b110, 3'b000, 8'h01);   // LDI R3 0x01 so rf_i no longer holds 0x5A
    cmd_valid = 1'b1; cmd_op = 3'b101; cmd_dst = 3'b111; cmd_src = 3'b000; cmd_imm = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (rf_o1_sel !== 3'b000) begin errors++; $display("FAIL mov_read_o1_sel: got %b want 000", rf_o1_sel); end
    checks++; if (rf_r_sel !== 4'b0000 || rf_t_sel !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL mov_read_enables: got r=%b t=%b busy=%b want 0000 0000 1", rf_r_sel, rf_t_sel, busy); end
    checks++; if (rf_i !== 8'h01) begin errors++; $display("FAIL mov_read_rf_i_hold: got %h want 01", rf_i); end
    @(negedge clk);
    checks++; if (rf_i !== 8'h5A) begin errors++; $display("FAIL mov_write_rf_i: got %h want 5a", rf_i); end
    checks++; if (rf_fun_sel !== 2'b01 || rf_r_sel !== 4'b0001 || rf_t_sel !== 4'b0000) begin errors++; $display("FAIL mov_write_ctrl: got fun=%b r=%b t=%b want 01 0001 0000", rf_fun_sel, rf_r_sel, rf_t_sel); end
    checks++; if (rf_o2_sel !== 3'b111 || done !== 1'b0) begin errors++; $display("FAIL mov_write_o2_done: got o2=%b done=%b want 111 0", rf_o2_sel, done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mov_done: got %b want 1", done); end
    checks++; if (rf_model[7] !== 8'h5A) begin errors++; $display("FAIL mov_model_r4: got %h want 5a", rf_model[7]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    cmd_valid = 1'b1; cmd_op = 3'b111; cmd_dst = 3'b101; cmd_src = 3'b000; cmd_imm = 8'd200;
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (rf_r_sel !== 4'b0100 || rf_fun_sel !== 2'b10 || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL subi_cycle%0d: got r=%b fun=%b busy=%b done=%b want 0100 10 1 0", j, rf_r_sel, rf_fun_sel, busy, done);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (rf_r_sel !== 4'b0000 || rf_t_sel !== 4'b0000) begin errors++; $display("FAIL midreset_enables: got r=%b t=%b want 0000 0000", rf_r_sel, rf_t_sel); end
    checks++; if (done !== 1'b0 || rf_fun_sel !== 2'b00) begin errors++; $display("FAIL midreset_done_fun: got done=%b fun=%b want 0 00", done, rf_fun_sel); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || rf_r_sel !== 4'b0000) begin
        errors++; $display("FAIL postreset_cycle%0d: got done=%b ready=%b r=%b want 0 1 0000", j, done, cmd_ready, rf_r_sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_op = 3'b110; cmd_dst = 3'b100; cmd_src = 3'b000; cmd_imm = 8'd2;
    @(negedge clk);
    // keep valid high and switch to the next command while ADDI is in flight
    cmd_op = 3'b010; cmd_dst = 3'b010; cmd_imm = 8'h33;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rf_r_sel !== 4'b1000 || rf_t_sel !== 4'b0000 || rf_fun_sel !== 2'b11 || rf_o2_sel !== 3'b100 || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_addi_cycle%0d: got r=%b t=%b fun=%b o2=%b ready=%b want 1000 0000 11 100 0", i, rf_r_sel, rf_t_sel, rf_fun_sel, rf_o2_sel, cmd_ready);
      end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_addi_done: got done=%b ready=%b want 1 1", done, cmd_ready); end
    checks++; if (rf_model[4] !== 8'h16) begin errors++; $display("FAIL b2b_model_r1: got %h want 16", rf_model[4]); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (rf_t_sel !== 4'b0010 || rf_r_sel !== 4'b0000 || rf_i !== 8'h33 || busy !== 1'b1) begin errors++; $display("FAIL b2b_ldi_exec: got t=%b r=%b i=%h busy=%b want 0010 0000 33 1", rf_t_sel, rf_r_sel, rf_i, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || rf_model[2] !== 8'h33) begin errors++; $display("FAIL b2b_ldi_done: got done=%b t3=%h want 1 33", done, rf_model[2]); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_addi();
    test_zero_and_nop();
    test_mov();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
